// File: rtl/framebuffer_fill_controller.sv
// Rectangle fill engine: one pixel write per free bus cycle, first write the cycle after start, optional vsync-timed frame swap.
// Backpressure: core_request stalls the engine with counters held; register writes to geometry are dropped while busy.
module framebuffer_fill_controller #(
    parameter logic [31:0] FB0_BASE       = 32'hFF00_0000,
    parameter logic [31:0] FB1_BASE       = 32'hFF10_0000,
    parameter logic [31:0] FRAME_SEL_ADDR = 32'hFF20_0604
) (
    input  logic        clock_core,
    input  logic        reset,
    input  logic        cfg_write,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_write_data,
    output logic [31:0] cfg_read_data,
    input  logic        core_request,
    input  logic        vsync,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [2:0]  bus_format,
    output logic        bus_write_enable,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT_VSYNC,
        ST_SWAP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [8:0]  r_x0;
    logic [7:0]  r_y0;
    logic [8:0]  r_width;
    logic [7:0]  r_height;
    logic [7:0]  r_color;
    logic        r_frame;
    logic        r_swap_after;
    logic        r_done;
    logic [8:0]  r_x;
    logic [7:0]  r_y;

    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_abort;
    logic [9:0]  w_x_sum;
    logic [9:0]  w_y_sum;
    logic [9:0]  w_x_end;
    logic [9:0]  w_y_end;
    logic        w_empty;
    logic        w_x_last;
    logic        w_y_last;
    logic        w_pix_wr;
    logic        w_last_pix;
    logic        w_finish;
    logic [31:0] w_pix_offset;
    logic [31:0] w_fb_base;
    logic        w_unused;

    assign w_ctrl_wr = cfg_write && (cfg_addr == 3'd0);
    assign w_start   = w_ctrl_wr && cfg_write_data[0];
    assign w_abort   = w_ctrl_wr && cfg_write_data[3];
    assign w_unused  = ^cfg_write_data[31:9];

    // Geometry registers cannot change while busy, so the clip window is derived from them directly.
    assign w_x_sum  = {1'b0, r_x0} + {1'b0, r_width};
    assign w_y_sum  = {2'b0, r_y0} + {2'b0, r_height};
    assign w_x_end  = (w_x_sum > 10'd320) ? 10'd320 : w_x_sum;
    assign w_y_end  = (w_y_sum > 10'd240) ? 10'd240 : w_y_sum;
    assign w_empty  = ({1'b0, r_x0} >= w_x_end) || ({2'b0, r_y0} >= w_y_end);
    assign w_x_last = (({1'b0, r_x} + 10'd1) == w_x_end);
    assign w_y_last = (({2'b0, r_y} + 10'd1) == w_y_end);

    assign w_pix_wr     = (r_state == ST_FILL) && !core_request && !w_empty;
    assign w_last_pix   = w_pix_wr && w_x_last && w_y_last;
    assign w_pix_offset = ({24'b0, r_y} << 8) + ({24'b0, r_y} << 6) + {23'b0, r_x};
    assign w_fb_base    = r_frame ? FB1_BASE : FB0_BASE;

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

    always_comb begin
        w_next_state     = r_state;
        w_finish         = 1'b0;
        bus_write_enable = 1'b0;
        bus_address      = 32'h0;
        bus_write_data   = 32'h0;
        bus_format       = 3'b000;
        case (r_state)
            ST_IDLE: begin
                if (w_start && !w_abort) begin
                    w_next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_pix_wr) begin
                    bus_write_enable = 1'b1;
                    bus_address      = w_fb_base + w_pix_offset;
                    bus_write_data   = {24'h0, r_color};
                end
                if (w_empty || w_last_pix) begin
                    if (r_swap_after) begin
                        w_next_state = ST_WAIT_VSYNC;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_finish     = 1'b1;
                    end
                end
            end
            ST_WAIT_VSYNC: begin
                if (vsync) begin
                    w_next_state = ST_SWAP;
                end
            end
            ST_SWAP: begin
                if (!core_request) begin
                    bus_write_enable = 1'b1;
                    bus_address      = FRAME_SEL_ADDR;
                    bus_write_data   = {31'b0, r_frame};
                    bus_format       = 3'b010;
                    w_next_state     = ST_IDLE;
                    w_finish         = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if ((r_state != ST_IDLE) && w_abort) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clock_core) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_x0         <= 9'd0;
            r_y0         <= 8'd0;
            r_width      <= 9'd0;
            r_height     <= 8'd0;
            r_color      <= 8'd0;
            r_frame      <= 1'b0;
            r_swap_after <= 1'b0;
            r_done       <= 1'b0;
            r_x          <= 9'd0;
            r_y          <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (cfg_write && (r_state == ST_IDLE)) begin
                case (cfg_addr)
                    3'd1:    r_x0     <= cfg_write_data[8:0];
                    3'd2:    r_y0     <= cfg_write_data[7:0];
                    3'd3:    r_width  <= cfg_write_data[8:0];
                    3'd4:    r_height <= cfg_write_data[7:0];
                    3'd5:    r_color  <= cfg_write_data[7:0];
                    default: ;
                endcase
            end
            if ((r_state == ST_IDLE) && w_start && !w_abort) begin
                r_frame      <= cfg_write_data[1];
                r_swap_after <= cfg_write_data[2];
                r_done       <= 1'b0;
                r_x          <= r_x0;
                r_y          <= r_y0;
            end else if (w_finish && !w_abort) begin
                r_done <= 1'b1;
            end
            // Raster advance only on an actual write so stalls never skip or repeat a pixel.
            if (w_pix_wr && !w_abort) begin
                if (w_x_last) begin
                    r_x <= r_x0;
                    r_y <= r_y + 8'd1;
                end else begin
                    r_x <= r_x + 9'd1;
                end
            end
        end
    end

    always_comb begin
        cfg_read_data = 32'h0;
        case (cfg_addr)
            3'd0:    cfg_read_data = {29'b0, r_swap_after, r_frame, 1'b0};
            3'd1:    cfg_read_data = {23'b0, r_x0};
            3'd2:    cfg_read_data = {24'b0, r_y0};
            3'd3:    cfg_read_data = {23'b0, r_width};
            3'd4:    cfg_read_data = {24'b0, r_height};
            3'd5:    cfg_read_data = {24'b0, r_color};
            3'd6:    cfg_read_data = {30'b0, r_done, busy};
            default: cfg_read_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_framebuffer_fill_controller.sv
// Directed bench for framebuffer_fill_controller: register access, fills, clipping, stalls, swap, abort, reset.
module tb_framebuffer_fill_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_write;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_write_data;
    logic [31:0] cfg_read_data;
    logic        core_request;
    logic        vsync;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [2:0]  bus_format;
    logic        bus_write_enable;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wa [0:15];
    logic [31:0] wd [0:15];
    logic [2:0]  wf [0:15];
    int          wc [0:15];
    int          n_wr;
    int          done_cyc;
    int          busy_cnt;
    int          nz_bad;

    logic [31:0] exp_a [0:5];
    int          exp_c [0:5];

    always #5 clk = ~clk;

    framebuffer_fill_controller dut (
        .clock_core       (clk),
        .reset            (reset),
        .cfg_write        (cfg_write),
        .cfg_addr         (cfg_addr),
        .cfg_write_data   (cfg_write_data),
        .cfg_read_data    (cfg_read_data),
        .core_request     (core_request),
        .vsync            (vsync),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_format       (bus_format),
        .bus_write_enable (bus_write_enable),
        .busy             (busy),
        .done             (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
        cfg_write      = 1'b1;
        cfg_addr       = a;
        cfg_write_data = d;
        @(posedge clk);
        #1;
        cfg_write      = 1'b0;
        cfg_write_data = 32'h0;
    endtask

    task automatic setup(input int x, input int y, input int w, input int h, input int c);
        cfg_wr(3'd1, x);
        cfg_wr(3'd2, y);
        cfg_wr(3'd3, w);
        cfg_wr(3'd4, h);
        cfg_wr(3'd5, c);
    endtask

    // Cycle 0 is the cycle right after the start write; one optional register write at ext_cyc.
    task automatic capture(input int ncyc, input logic [63:0] cr, input logic [63:0] vs,
                           input int ext_cyc, input logic [2:0] ext_a, input logic [31:0] ext_d);
        n_wr = 0; done_cyc = -1; busy_cnt = 0; nz_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            core_request = cr[c];
            vsync        = vs[c];
            if (c == ext_cyc) begin
                cfg_write      = 1'b1;
                cfg_addr       = ext_a;
                cfg_write_data = ext_d;
            end
            #1;
            if (bus_write_enable) begin
                if (n_wr < 16) begin
                    wa[n_wr] = bus_address;
                    wd[n_wr] = bus_write_data;
                    wf[n_wr] = bus_format;
                    wc[n_wr] = c;
                end
                n_wr++;
            end else if (bus_address != 0 || bus_write_data != 0 || bus_format != 0) begin
                nz_bad++;
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            cfg_write      = 1'b0;
            cfg_write_data = 32'h0;
        end
        core_request = 1'b0;
        vsync        = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cfg_write = 1'b0; cfg_addr = 3'd0; cfg_write_data = 32'h0;
        core_request = 1'b0; vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", bus_write_enable, 0);
        chk("rst_addr", bus_address, 0);
        cfg_addr = 3'd6; #1;
        chk("rst_status", cfg_read_data, 0);
        cfg_addr = 3'd7; #1;
        chk("rd_idx7", cfg_read_data, 0);

        // Basic 3x2 fill at (0x10, 2); geometry write during busy must be dropped.
        setup(16, 2, 3, 2, 8'h1F);
        cfg_addr = 3'd1; #1;
        chk("rd_x0", cfg_read_data, 16);
        cfg_wr(3'd0, 32'h1);
        capture(10, 64'h0, 64'h0, 1, 3'd1, 32'd100);
        exp_a = '{32'hFF000290, 32'hFF000291, 32'hFF000292, 32'hFF0003D0, 32'hFF0003D1, 32'hFF0003D2};
        exp_c = '{0, 1, 2, 3, 4, 5};
        chk("t1_nwr", n_wr, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t1_addr%0d", i), wa[i], exp_a[i]);
            chk($sformatf("t1_data%0d", i), wd[i], 32'h0000001F);
            chk($sformatf("t1_fmt%0d", i), {29'b0, wf[i]}, 0);
            chk($sformatf("t1_cyc%0d", i), wc[i], exp_c[i]);
        end
        chk("t1_done_cyc", done_cyc, 6);
        chk("t1_busy_cnt", busy_cnt, 6);
        chk("t1_idle_zero", nz_bad, 0);
        cfg_addr = 3'd1; #1;
        chk("t1_x0_kept", cfg_read_data, 16);
        cfg_addr = 3'd6; #1;
        chk("t1_status", cfg_read_data, 32'h2);

        // Same fill stalled by the core on cycles 2-3.
        cfg_wr(3'd0, 32'h1);
        capture(12, 64'h0C, 64'h0, -1, 3'd0, 32'h0);
        exp_c = '{0, 1, 4, 5, 6, 7};
        chk("t2_nwr", n_wr, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_addr%0d", i), wa[i], exp_a[i]);
            chk($sformatf("t2_cyc%0d", i), wc[i], exp_c[i]);
        end
        chk("t2_done_cyc", done_cyc, 8);
        chk("t2_idle_zero", nz_bad, 0);

        // Clipped at the bottom-right corner.
        setup(318, 239, 5, 5, 8'hC7);
        cfg_wr(3'd0, 32'h1);
        capture(6, 64'h0, 64'h0, -1, 3'd0, 32'h0);
        chk("t3_nwr", n_wr, 2);
        chk("t3_addr0", wa[0], 32'hFF012BFE);
        chk("t3_addr1", wa[1], 32'hFF012BFF);
        chk("t3_data0", wd[0], 32'h000000C7);
        chk("t3_done_cyc", done_cyc, 2);

        // Empty fill.
        setup(0, 0, 0, 4, 8'h11);
        cfg_wr(3'd0, 32'h1);
        capture(4, 64'h0, 64'h0, -1, 3'd0, 32'h0);
        chk("t4_nwr", n_wr, 0);
        chk("t4_busy_cnt", busy_cnt, 1);
        chk("t4_done_cyc", done_cyc, 1);

        // 1x1 in frame 1 with swap; vsync coincident with the pixel is ignored, later one is honoured.
        setup(5, 1, 1, 1, 8'h55);
        cfg_wr(3'd0, 32'h7);
        capture(10, 64'h0, 64'h21, -1, 3'd0, 32'h0);
        chk("t5_nwr", n_wr, 2);
        chk("t5_addr0", wa[0], 32'hFF100145);
        chk("t5_data0", wd[0], 32'h00000055);
        chk("t5_cyc0", wc[0], 0);
        chk("t5_addr1", wa[1], 32'hFF200604);
        chk("t5_data1", wd[1], 32'h00000001);
        chk("t5_fmt1", {29'b0, wf[1]}, 2);
        chk("t5_cyc1", wc[1], 6);
        chk("t5_busy_cnt", busy_cnt, 7);
        chk("t5_done_cyc", done_cyc, 7);
        cfg_addr = 3'd0; #1;
        chk("t5_ctrl_rd", cfg_read_data, 32'h6);

        // 4x4 fill aborted (with start also set) during the third pixel.
        setup(0, 0, 4, 4, 8'hC7);
        cfg_wr(3'd0, 32'h1);
        capture(6, 64'h0, 64'h0, 2, 3'd0, 32'h9);
        chk("t6_nwr", n_wr, 3);
        chk("t6_addr2", wa[2], 32'hFF000002);
        chk("t6_busy_cnt", busy_cnt, 3);
        chk("t6_done_cyc", done_cyc, -1);
        cfg_addr = 3'd6; #1;
        chk("t6_status", cfg_read_data, 0);

        // Reset in the middle of a fill.
        cfg_wr(3'd0, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        cfg_addr = 3'd3; #1;
        chk("t7_we", bus_write_enable, 0);
        chk("t7_addr", bus_address, 0);
        chk("t7_data", bus_write_data, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_width", cfg_read_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
